// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the MEM/WB stage and the
// forwarding unit.
package cpu_pkg;

    typedef logic [2:0] mem_type_t;

    localparam logic [1:0] MT_BYTE = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_WORD = 2'b10;
    localparam logic [1:0] MT_LR   = 2'b11;

    localparam int EXC_NONE = 0;

endpackage

// File: rtl/load_formatter.sv
// Aligns and extends a returned load word; shared with forwarding.
// MEMWB_LWLR_EN enables the LWL/LWR merge with rt_old.
module load_formatter
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] mem_data,
    input  logic [1:0]    addr,
    input  mem_type_t     mem_type,
    input  logic [DW-1:0] rt_old,
    output logic [DW-1:0] result
);

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] lr_word;
    logic          zext;

    assign zext     = mem_type[2];
    assign half_sel = addr[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        byte_sel = mem_data[7:0];
        unique case (addr)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            2'd3: byte_sel = mem_data[31:24];
        endcase
    end

`ifdef MEMWB_LWLR_EN
    logic [DW-1:0] lwl_word;
    logic [DW-1:0] lwr_word;
    logic [DW-1:0] lwl_keep;
    logic [DW-1:0] lwr_keep;

    // ~addr == 3-addr: LWL shifts the low lanes up, LWR shifts high lanes down
    assign lwl_word = mem_data << {~addr, 3'b000};
    assign lwl_keep = ~({DW{1'b1}} << {~addr, 3'b000});
    assign lwr_word = mem_data >> {addr, 3'b000};
    assign lwr_keep = ~({DW{1'b1}} >> {addr, 3'b000});

    assign lr_word = zext ? (lwr_word | (rt_old & lwr_keep))
                          : (lwl_word | (rt_old & lwl_keep));
`else
    logic unused_rt;

    assign unused_rt = ^rt_old;
    assign lr_word   = mem_data;
`endif

    always_comb begin
        result = mem_data;
        unique case (mem_type[1:0])
            MT_BYTE: result = zext ? {{(DW-8){1'b0}}, byte_sel}
                                   : {{(DW-8){byte_sel[7]}}, byte_sel};
            MT_HALF: result = zext ? {{(DW-16){1'b0}}, half_sel}
                                   : {{(DW-16){half_sel[15]}}, half_sel};
            MT_WORD: result = mem_data;
            MT_LR:   result = lr_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load write-back formatting.
// Define MEMWB_LWLR_EN to enable LWL/LWR merging.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 7,
    parameter int EXC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             MemtoRegW,
    input  logic             RegWriteW,
    input  logic             HI_LO_write_enableW,
    input  logic [63:0]      HI_LO_dataW,
    input  logic [DW-1:0]    ALUoutW,
    input  logic [RW-1:0]    WriteRegisterW,
    input  logic [DW-1:0]    PCout,
    input  mem_type_t        MemReadTypeW,
    input  logic [EXC_W-1:0] exception_in,
    input  logic             is_ds_in,
    input  logic [DW-1:0]    Memdata,
    input  logic [DW-1:0]    rt_old,
    output logic             RegWriteWB,
    output logic [RW-1:0]    WriteRegisterWB,
    output logic [DW-1:0]    ResultWB,
    output logic             HI_LO_weWB,
    output logic [63:0]      HI_LO_dataWB,
    output logic [DW-1:0]    PCWB,
    output logic             is_dsWB,
    output logic             validWB
);

    logic             valid_r;
    logic             memtoreg_r;
    logic             regwrite_r;
    logic             hilo_we_r;
    logic [63:0]      hilo_data_r;
    logic [DW-1:0]    alu_r;
    logic [RW-1:0]    wreg_r;
    logic [DW-1:0]    pc_r;
    mem_type_t        mtype_r;
    logic [EXC_W-1:0] exc_r;
    logic             is_ds_r;
    logic [DW-1:0]    memdata_r;
    logic [DW-1:0]    load_word;
    logic             no_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            valid_r     <= 1'b0;
            memtoreg_r  <= 1'b0;
            regwrite_r  <= 1'b0;
            hilo_we_r   <= 1'b0;
            hilo_data_r <= '0;
            alu_r       <= '0;
            wreg_r      <= '0;
            pc_r        <= '0;
            mtype_r     <= '0;
            exc_r       <= '0;
            is_ds_r     <= 1'b0;
            memdata_r   <= '0;
        end else if (!stall) begin
            valid_r     <= 1'b1;
            memtoreg_r  <= MemtoRegW;
            regwrite_r  <= RegWriteW;
            hilo_we_r   <= HI_LO_write_enableW;
            hilo_data_r <= HI_LO_dataW;
            alu_r       <= ALUoutW;
            wreg_r      <= WriteRegisterW;
            pc_r        <= PCout;
            mtype_r     <= MemReadTypeW;
            exc_r       <= exception_in;
            is_ds_r     <= is_ds_in;
            memdata_r   <= Memdata;
        end
    end

    load_formatter #(.DW(DW)) u_fmt (
        .mem_data (memdata_r),
        .addr     (alu_r[1:0]),
        .mem_type (mtype_r),
        .rt_old   (rt_old),
        .result   (load_word)
    );

    assign no_exc          = (exc_r == EXC_W'(EXC_NONE));
    assign RegWriteWB      = valid_r & regwrite_r & no_exc;
    assign HI_LO_weWB      = valid_r & hilo_we_r & no_exc;
    assign ResultWB        = memtoreg_r ? load_word : alu_r;
    assign WriteRegisterWB = wreg_r;
    assign HI_LO_dataWB    = hilo_data_r;
    assign PCWB            = pc_r;
    assign is_dsWB         = is_ds_r;
    assign validWB         = valid_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, corner
// sequences and a randomized run against a byte-lane reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        MemtoRegW;
    logic        RegWriteW;
    logic        HI_LO_write_enableW;
    logic [63:0] HI_LO_dataW;
    logic [31:0] ALUoutW;
    logic [6:0]  WriteRegisterW;
    logic [31:0] PCout;
    logic [2:0]  MemReadTypeW;
    logic [3:0]  exception_in;
    logic        is_ds_in;
    logic [31:0] Memdata;
    logic [31:0] rt_old;
    logic        RegWriteWB;
    logic [6:0]  WriteRegisterWB;
    logic [31:0] ResultWB;
    logic        HI_LO_weWB;
    logic [63:0] HI_LO_dataWB;
    logic [31:0] PCWB;
    logic        is_dsWB;
    logic        validWB;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .flush               (flush),
        .MemtoRegW           (MemtoRegW),
        .RegWriteW           (RegWriteW),
        .HI_LO_write_enableW (HI_LO_write_enableW),
        .HI_LO_dataW         (HI_LO_dataW),
        .ALUoutW             (ALUoutW),
        .WriteRegisterW      (WriteRegisterW),
        .PCout               (PCout),
        .MemReadTypeW        (MemReadTypeW),
        .exception_in        (exception_in),
        .is_ds_in            (is_ds_in),
        .Memdata             (Memdata),
        .rt_old              (rt_old),
        .RegWriteWB          (RegWriteWB),
        .WriteRegisterWB     (WriteRegisterWB),
        .ResultWB            (ResultWB),
        .HI_LO_weWB          (HI_LO_weWB),
        .HI_LO_dataWB        (HI_LO_dataWB),
        .PCWB                (PCWB),
        .is_dsWB             (is_dsWB),
        .validWB             (validWB)
    );

    typedef struct {
        logic        valid, m2r, rw, hl, ds;
        logic [63:0] hld;
        logic [31:0] alu, pc, mem;
        logic [6:0]  wr;
        logic [2:0]  mt;
        logic [3:0]  exc;
    } st_t;

    st_t st;

    typedef struct {
        logic        m2r, rw, hl;
        logic [2:0]  mt;
        logic [31:0] alu, mem;
        logic [3:0]  exc;
        logic [31:0] res;
        logic        erw, ehl;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] model_load(input logic [31:0] mem,
                                               input int a,
                                               input logic [2:0] mt,
                                               input logic [31:0] rt);
        logic [7:0] m[4];
        logic [7:0] r[4];
        int v;
        for (int k = 0; k < 4; k++) begin
            m[k] = mem[8*k +: 8];
            r[k] = rt[8*k +: 8];
        end
        case (mt[1:0])
            2'b00: begin
                v = int'(m[a]);
                if (!mt[2] && v >= 128) v -= 256;
                return 32'(v);
            end
            2'b01: begin
                v = int'(m[2*(a/2)]) + 256 * int'(m[2*(a/2)+1]);
                if (!mt[2] && v >= 32768) v -= 65536;
                return 32'(v);
            end
            2'b10: return mem;
            default: begin
`ifdef MEMWB_LWLR_EN
                if (!mt[2]) begin
                    for (int j = 0; j <= a; j++) r[3-j] = m[a-j];
                end else begin
                    for (int j = 0; j <= 3 - a; j++) r[j] = m[a+j];
                end
                return {r[3], r[2], r[1], r[0]};
`else
                return mem;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic model_edge();
        if (flush) begin
            st = '{default: '0};
        end else if (!stall) begin
            st.valid = 1'b1;
            st.m2r = MemtoRegW;
            st.rw  = RegWriteW;
            st.hl  = HI_LO_write_enableW;
            st.hld = HI_LO_dataW;
            st.alu = ALUoutW;
            st.wr  = WriteRegisterW;
            st.pc  = PCout;
            st.mt  = MemReadTypeW;
            st.exc = exception_in;
            st.ds  = is_ds_in;
            st.mem = Memdata;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] er;
        logic ok;
        ok = (st.exc == 4'd0);
        er = st.m2r ? model_load(st.mem, int'(st.alu[1:0]), st.mt, rt_old)
                    : st.alu;
        chk({tag, ".RegWriteWB"}, 64'(RegWriteWB), 64'(st.valid & st.rw & ok));
        chk({tag, ".HI_LO_weWB"}, 64'(HI_LO_weWB), 64'(st.valid & st.hl & ok));
        chk({tag, ".ResultWB"}, 64'(ResultWB), 64'(er));
        chk({tag, ".WriteRegisterWB"}, 64'(WriteRegisterWB), 64'(st.wr));
        chk({tag, ".HI_LO_dataWB"}, HI_LO_dataWB, st.hld);
        chk({tag, ".PCWB"}, 64'(PCWB), 64'(st.pc));
        chk({tag, ".is_dsWB"}, 64'(is_dsWB), 64'(st.ds));
        chk({tag, ".validWB"}, 64'(validWB), 64'(st.valid));
    endtask

    task automatic randomize_inputs();
        MemtoRegW           = 1'($urandom);
        RegWriteW           = 1'($urandom);
        HI_LO_write_enableW = 1'($urandom);
        HI_LO_dataW         = {$urandom, $urandom};
        ALUoutW             = $urandom;
        WriteRegisterW      = 7'($urandom);
        PCout               = $urandom;
        MemReadTypeW        = 3'($urandom);
        exception_in        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        is_ds_in            = 1'($urandom);
        Memdata             = $urandom;
        rt_old              = $urandom;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        MemtoRegW           = v.m2r;
        RegWriteW           = v.rw;
        HI_LO_write_enableW = v.hl;
        MemReadTypeW        = v.mt;
        ALUoutW             = v.alu;
        Memdata             = v.mem;
        exception_in        = v.exc;
        PCout               = 32'h400 + 32'(4 * idx);
        WriteRegisterW      = 7'(idx + 1);
        is_ds_in            = 1'(idx);
        HI_LO_dataW         = {$urandom, $urandom};
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 0, 32'hFFFF_FF80, 1, 0};
        tbl[1] = '{1, 1, 0, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 0, 32'h0000_0080, 1, 0};
        tbl[2] = '{1, 1, 0, 3'b001, 32'h0000_2002, 32'h8001_1234, 0, 32'hFFFF_8001, 1, 0};
        tbl[3] = '{1, 1, 0, 3'b101, 32'h0000_2002, 32'h8001_1234, 0, 32'h0000_8001, 1, 0};
        tbl[4] = '{1, 1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 0};
        tbl[5] = '{0, 1, 0, 3'b010, 32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1, 0};
        tbl[6] = '{0, 1, 1, 3'b000, 32'h0000_0005, 32'h0000_0000, 4, 32'h0000_0005, 0, 0};
        tbl[7] = '{0, 0, 1, 3'b000, 32'h0000_0006, 32'h0000_0000, 0, 32'h0000_0006, 0, 1};
        tbl[8] = '{1, 1, 0, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 0, 32'h0000_007F, 1, 0};
        tbl[9] = '{1, 1, 0, 3'b001, 32'h0000_2001, 32'h8001_1234, 0, 32'h0000_1234, 1, 0};

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        MemtoRegW = 0; RegWriteW = 0; HI_LO_write_enableW = 0;
        HI_LO_dataW = '0; ALUoutW = '0; WriteRegisterW = '0; PCout = '0;
        MemReadTypeW = '0; exception_in = '0; is_ds_in = 0;
        Memdata = '0; rt_old = 32'hAABB_CCDD;
        st = '{default: '0};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        stall = 1'b1;
        rst = 1'b0;
        step();
        check_all("post_reset_stalled");
        stall = 1'b0;

        foreach (tbl[i]) begin
            apply_vec(tbl[i], i);
            step();
            chk($sformatf("vec%0d.ResultWB", i), 64'(ResultWB), 64'(tbl[i].res));
            chk($sformatf("vec%0d.RegWriteWB", i), 64'(RegWriteWB), 64'(tbl[i].erw));
            chk($sformatf("vec%0d.HI_LO_weWB", i), 64'(HI_LO_weWB), 64'(tbl[i].ehl));
            chk($sformatf("vec%0d.PCWB", i), 64'(PCWB), 64'(32'h400 + 32'(4 * i)));
            chk($sformatf("vec%0d.validWB", i), 64'(validWB), 64'd1);
            check_all($sformatf("vec%0d", i));
        end

        apply_vec(tbl[0], 0);
        step();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            rt_old = 32'hAABB_CCDD;
            step();
            chk($sformatf("stall%0d.ResultWB", c), 64'(ResultWB), 64'(32'hFFFF_FF80));
            check_all($sformatf("stall%0d", c));
        end
        flush = 1'b1;
        step();
        chk("flush_stall.validWB", 64'(validWB), 64'd0);
        chk("flush_stall.RegWriteWB", 64'(RegWriteWB), 64'd0);
        check_all("flush_stall");
        flush = 1'b0;
        stall = 1'b0;

        apply_vec(tbl[6], 6);
        step();
        chk("exc.PCWB", 64'(PCWB), 64'(32'h400 + 32'd24));
        chk("exc.RegWriteWB", 64'(RegWriteWB), 64'd0);

        apply_vec(tbl[4], 4);
        step();
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        st = '{default: '0};
        #1;
        check_all("rst_mid_stall");
        rst = 1'b0;
        step();
        check_all("rst_release_stalled");
        stall = 1'b0;
        step();
        check_all("rst_release_run");

`ifdef MEMWB_LWLR_EN
        MemtoRegW = 1; ALUoutW = 32'h0000_0041; Memdata = 32'h4433_2211;
        rt_old = 32'hAABB_CCDD; MemReadTypeW = 3'b011; exception_in = 0;
        step();
        chk("lwl_a1.ResultWB", 64'(ResultWB), 64'(32'h2211_CCDD));
        MemReadTypeW = 3'b111;
        step();
        chk("lwr_a1.ResultWB", 64'(ResultWB), 64'(32'hAA44_3322));
`endif

        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
            check_all($sformatf("rand%0d", n));
        end
        flush = 1'b0;
        stall = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
